// File: rtl/cnn_pkg.sv
// Shared CNN front-end types and width helpers.
package cnn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      START,
      RUN
   } loader_state_e;

   function automatic int unsigned calc_lanes(input int unsigned inout_width,
                                              input int unsigned data_width);
      return inout_width / data_width;
   endfunction

   function automatic int unsigned calc_addr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs a pixel stream into lane words; exposes the word and lane mask as they
// will look once the current pixel is included.
module pixel_packer
   import cnn_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 16,
   parameter  int unsigned LANES      = 16,
   localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int unsigned WORD_W     = LANES * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] pix,
   output logic                  lane_full_c,
   output logic [WORD_W-1:0]     word_c,
   output logic [LANES-1:0]      mask_c
);

   logic [LANE_W-1:0] lane_cnt;
   logic [WORD_W-1:0] word_q;

   // Current pixel merged into its lane; mask covers lanes 0..lane_cnt.
   always_comb begin
      lane_full_c = (lane_cnt == LANE_W'(LANES - 1));
      word_c      = word_q;
      mask_c      = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (lane_cnt == LANE_W'(i)) begin
            word_c[i*DATA_WIDTH +: DATA_WIDTH] = pix;
         end
         mask_c[i] = (LANE_W'(i) <= lane_cnt);
      end
   end

   // Word buffer is zeroed on wrap so a trailing partial word has clean unused lanes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt <= '0;
         word_q   <= '0;
      end else if (clr) begin
         lane_cnt <= '0;
         word_q   <= '0;
      end else if (push) begin
         if (lane_full_c) begin
            lane_cnt <= '0;
            word_q   <= '0;
         end else begin
            lane_cnt <= lane_cnt + LANE_W'(1);
            word_q   <= word_c;
         end
      end
   end

endmodule

// File: rtl/ifm_stream_loader.sv
// Loads one image frame from a pixel stream into IFM RAM, then starts the CNN.
// Optional LOADER_CHECKSUM_EN adds a 32-bit sum of all accepted pixels.
module ifm_stream_loader
   import cnn_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH   = 16,
   parameter  int unsigned INOUT_WIDTH  = 256,
   parameter  int unsigned IFM_RAM_SIZE = 519168,
   parameter  int unsigned IMG_SIZE     = 318,
   parameter  int unsigned IMG_CHANNEL  = 3,
   localparam int unsigned LANES        = calc_lanes(INOUT_WIDTH, DATA_WIDTH),
   localparam int unsigned ADDR_W       = calc_addr_w(IFM_RAM_SIZE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_start,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   input  logic                   s_last,
   output logic                   ifm_wr_en,
   output logic [ADDR_W-1:0]      ifm_wr_addr,
   output logic [INOUT_WIDTH-1:0] ifm_wr_data,
   output logic [LANES-1:0]       ifm_wr_mask,
   output logic                   start_CNN,
   input  logic                   done_CNN,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   err_len
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [31:0]            chksum
`endif
);

   localparam int unsigned TOTAL = IMG_SIZE * IMG_SIZE * IMG_CHANNEL;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);

   loader_state_e          state, state_next;
   logic [CNT_W-1:0]       pix_cnt;
   logic [ADDR_W-1:0]      word_base;

   logic                   start_acc_c, pix_acc_c, final_c, abort_c;
   logic                   lane_full_c;
   logic [INOUT_WIDTH-1:0] word_c;
   logic [LANES-1:0]       mask_c;

   logic                   s_ready_d, busy_d, start_d, frame_done_d, wr_en_d;
   logic [ADDR_W-1:0]      wr_addr_d;
   logic [INOUT_WIDTH-1:0] wr_data_d;
   logic [LANES-1:0]       wr_mask_d;

   assign start_acc_c = (state == IDLE) && load_start;
   assign pix_acc_c   = s_valid && s_ready;
   assign final_c     = (pix_cnt == CNT_W'(TOTAL - 1));
   assign abort_c     = pix_acc_c && s_last && !final_c;

   pixel_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (start_acc_c || abort_c),
      .push        (pix_acc_c),
      .pix         (s_data),
      .lane_full_c (lane_full_c),
      .word_c      (word_c),
      .mask_c      (mask_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load_start) state_next = LOAD;
         LOAD: begin
            if (pix_acc_c) begin
               if (final_c)     state_next = FLUSH;
               else if (s_last) state_next = IDLE;
            end
         end
         FLUSH:   state_next = START;
         START:   state_next = RUN;
         RUN:     if (done_CNN) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   // The final pixel's word (full or partial) is written here, landing in the FLUSH cycle.
   always_comb begin
      s_ready_d    = (state_next == LOAD);
      busy_d       = (state_next != IDLE);
      start_d      = (state_next == START);
      frame_done_d = (state == RUN) && done_CNN;
      wr_en_d      = 1'b0;
      wr_addr_d    = '0;
      wr_data_d    = '0;
      wr_mask_d    = '0;
      if (pix_acc_c && !abort_c && (lane_full_c || final_c)) begin
         wr_en_d   = 1'b1;
         wr_addr_d = word_base;
         wr_data_d = word_c;
         wr_mask_d = mask_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready     <= 1'b0;
         busy        <= 1'b0;
         start_CNN   <= 1'b0;
         frame_done  <= 1'b0;
         ifm_wr_en   <= 1'b0;
         ifm_wr_addr <= '0;
         ifm_wr_data <= '0;
         ifm_wr_mask <= '0;
         err_len     <= 1'b0;
         pix_cnt     <= '0;
         word_base   <= '0;
      end else begin
         s_ready     <= s_ready_d;
         busy        <= busy_d;
         start_CNN   <= start_d;
         frame_done  <= frame_done_d;
         ifm_wr_en   <= wr_en_d;
         ifm_wr_addr <= wr_addr_d;
         ifm_wr_data <= wr_data_d;
         ifm_wr_mask <= wr_mask_d;
         if (start_acc_c) begin
            pix_cnt   <= '0;
            word_base <= '0;
            err_len   <= 1'b0;
         end else begin
            if (pix_acc_c && !final_c) pix_cnt <= pix_cnt + CNT_W'(1);
            if (wr_en_d) word_base <= word_base + ADDR_W'(LANES);
            if (abort_c || (pix_acc_c && final_c && !s_last)) err_len <= 1'b1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           chksum <= '0;
      else if (start_acc_c) chksum <= '0;
      else if (pix_acc_c)   chksum <= chksum + 32'(s_data);
   end
`endif

endmodule

// File: tb/tb_ifm_stream_loader.sv
// Scoreboard bench for ifm_stream_loader on a reduced 10x10x3 image (300 pixels).
module tb_ifm_stream_loader;

   localparam int TOTAL = 300;

   typedef struct packed {
      logic [18:0]  addr;
      logic [255:0] data;
      logic [15:0]  mask;
   } wr_t;

   logic         clk, rst_n, load_start, s_valid, s_ready, s_last;
   logic [15:0]  s_data;
   logic         ifm_wr_en, start_CNN, done_CNN, frame_done, busy, err_len;
   logic [18:0]  ifm_wr_addr;
   logic [255:0] ifm_wr_data;
   logic [15:0]  ifm_wr_mask;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]  chksum;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ifm_stream_loader #(.IMG_SIZE(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .ifm_wr_en   (ifm_wr_en),
      .ifm_wr_addr (ifm_wr_addr),
      .ifm_wr_data (ifm_wr_data),
      .ifm_wr_mask (ifm_wr_mask),
      .start_CNN   (start_CNN),
      .done_CNN    (done_CNN),
      .frame_done  (frame_done),
      .busy        (busy),
      .err_len     (err_len)
`ifdef LOADER_CHECKSUM_EN
      ,
      .chksum      (chksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: records writes and pulse events on the falling edge.
   wr_t obs_arr [0:1023];
   int  n_obs = 0, n_start = 0, n_fd = 0, cyc = 0, last_wr_cyc = 0, start_cyc = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && ifm_wr_en && n_obs < 1024) begin
         obs_arr[n_obs] <= '{addr: ifm_wr_addr, data: ifm_wr_data, mask: ifm_wr_mask};
         n_obs          <= n_obs + 1;
         last_wr_cyc    <= cyc;
      end
      if (rst_n && start_CNN) begin
         n_start   <= n_start + 1;
         start_cyc <= cyc;
      end
      if (rst_n && frame_done) n_fd <= n_fd + 1;
   end

   // Reference packer model feeding the expected-write queue.
   wr_t          exp_q[$];
   int           rd_ptr = 0;
   int           model_lane, model_addr;
   logic [255:0] model_word;

   task automatic model_begin();
      model_lane = 0;
      model_addr = 0;
      model_word = '0;
   endtask

   task automatic model_pixel(input int k);
      wr_t e;
      model_word[model_lane*16 +: 16] = 16'(k);
      model_lane++;
      if (model_lane == 16) begin
         e.addr = 19'(model_addr);
         e.data = model_word;
         e.mask = 16'hFFFF;
         exp_q.push_back(e);
         model_addr += 16;
         model_lane  = 0;
         model_word  = '0;
      end
   endtask

   task automatic model_end();
      wr_t e;
      if (model_lane > 0) begin
         e.addr = 19'(model_addr);
         e.data = model_word;
         e.mask = 16'((32'd1 << model_lane) - 32'd1);
         exp_q.push_back(e);
      end
      model_begin();
   endtask

   task automatic pulse_load();
      @(negedge clk) load_start = 1'b1;
      @(negedge clk) load_start = 1'b0;
   endtask

   // Streams ramp pixels k0..k_end-1; pixel k carries k[15:0].
   task automatic send_pixels(input int k0, input int k_end, input int last_idx,
                              input int idle_pct, output int k_out);
      int k     = k0;
      int guard = 0;
      while (k < k_end && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (idle_pct > 0 && $urandom_range(99, 0) < idle_pct) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = 16'(k);
            s_last  = (k == last_idx);
            if (s_ready) begin
               model_pixel(k);
               k++;
            end
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      k_out   = k;
   endtask

   task automatic fire_done(input int wait_cyc);
      repeat (wait_cyc) @(negedge clk);
      done_CNN = 1'b1;
      repeat (3) @(negedge clk);
      done_CNN = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks++;
      if ({s_ready, busy, start_CNN, frame_done, ifm_wr_en, err_len} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, expected 000000",
                  {s_ready, busy, start_CNN, frame_done, ifm_wr_en, err_len});
      end
      n_checks++;
      if ({ifm_wr_addr, ifm_wr_mask, ifm_wr_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_wr: got addr=%0d mask=%h, expected 0", ifm_wr_addr, ifm_wr_mask);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, s_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy/s_ready=%b, expected 00", {busy, s_ready});
      end
   endtask

   task automatic test_full_frame(input int idle_pct);
      int  k, st0, fd0;
      wr_t e, o;
      st0 = n_start;
      fd0 = n_fd;
      n_checks++;
      if (s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_idle: got %b, expected 0", s_ready);
      end
      pulse_load();
      n_checks++;
      if ({busy, s_ready, err_len} !== 3'b110) begin
         n_fail++;
         $display("FAIL load_entry: got busy/ready/err=%b, expected 110", {busy, s_ready, err_len});
      end
      model_begin();
      send_pixels(0, TOTAL, TOTAL - 1, idle_pct, k);
      model_end();
      n_checks++;
      if (k !== TOTAL) begin
         n_fail++;
         $display("FAIL frame_transfer: got %0d pixels, expected %0d", k, TOTAL);
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (n_obs - rd_ptr !== exp_q.size()) begin
         n_fail++;
         $display("FAIL wr_count: got %0d, expected %0d", n_obs - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < n_obs) begin
         e = exp_q.pop_front();
         o = obs_arr[rd_ptr];
         rd_ptr++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL wr_word: got addr=%0d mask=%h data=%h, expected addr=%0d mask=%h data=%h",
                     o.addr, o.mask, o.data, e.addr, e.mask, e.data);
         end
      end
      exp_q.delete();
      rd_ptr = n_obs;
      n_checks++;
      if (n_obs < 1 || obs_arr[n_obs-1].mask !== 16'h0FFF || obs_arr[n_obs-1].addr !== 19'd288) begin
         n_fail++;
         $display("FAIL last_write: got addr=%0d mask=%h, expected addr=288 mask=0fff",
                  obs_arr[n_obs-1].addr, obs_arr[n_obs-1].mask);
      end
      n_checks++;
      if (n_start - st0 !== 1 || start_cyc <= last_wr_cyc) begin
         n_fail++;
         $display("FAIL start_pulse: got %0d pulses at cyc %0d (last write %0d), expected 1 after write",
                  n_start - st0, start_cyc, last_wr_cyc);
      end
      n_checks++;
      if ({busy, s_ready, err_len} !== 3'b100) begin
         n_fail++;
         $display("FAIL run_state: got busy/ready/err=%b, expected 100", {busy, s_ready, err_len});
      end
`ifdef LOADER_CHECKSUM_EN
      n_checks++;
      if (chksum !== 32'(TOTAL * (TOTAL - 1) / 2)) begin
         n_fail++;
         $display("FAIL chksum: got %0d, expected %0d", chksum, TOTAL * (TOTAL - 1) / 2);
      end
`endif
      fire_done(50);
      n_checks++;
      if (n_fd - fd0 !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_done: got %0d pulses busy=%b, expected 1 pulse busy=0", n_fd - fd0, busy);
      end
   endtask

   task automatic test_short_frame();
      int  k, st0;
      wr_t e, o;
      st0 = n_start;
      pulse_load();
      model_begin();
      send_pixels(0, 101, 100, 0, k);
      model_begin();
      n_checks++;
      if ({busy, s_ready, err_len} !== 3'b001) begin
         n_fail++;
         $display("FAIL short_abort: got busy/ready/err=%b, expected 001", {busy, s_ready, err_len});
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (n_obs - rd_ptr !== 6 || exp_q.size() !== 6) begin
         n_fail++;
         $display("FAIL short_wr_count: got %0d, expected 6", n_obs - rd_ptr);
      end
      while (exp_q.size() > 0 && rd_ptr < n_obs) begin
         e = exp_q.pop_front();
         o = obs_arr[rd_ptr];
         rd_ptr++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL short_wr_word: got addr=%0d mask=%h data=%h, expected addr=%0d mask=%h data=%h",
                     o.addr, o.mask, o.data, e.addr, e.mask, e.data);
         end
      end
      exp_q.delete();
      rd_ptr = n_obs;
      n_checks++;
      if (n_start !== st0) begin
         n_fail++;
         $display("FAIL short_no_start: got %0d pulses, expected 0", n_start - st0);
      end
      pulse_load();
      n_checks++;
      if ({busy, err_len} !== 2'b10) begin
         n_fail++;
         $display("FAIL err_clear: got busy/err=%b, expected 10", {busy, err_len});
      end
   endtask

   // Enters already in LOAD from the previous test's load_start.
   task automatic test_reset_midframe();
      int  k;
      wr_t e, o;
      model_begin();
      send_pixels(0, 150, -1, 0, k);
      repeat (3) @(negedge clk);
      n_checks++;
      if (n_obs - rd_ptr !== 9 || exp_q.size() !== 9) begin
         n_fail++;
         $display("FAIL pre_reset_wr_count: got %0d, expected 9", n_obs - rd_ptr);
      end
      while (exp_q.size() > 0 && rd_ptr < n_obs) begin
         e = exp_q.pop_front();
         o = obs_arr[rd_ptr];
         rd_ptr++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL pre_reset_wr_word: got addr=%0d data=%h, expected addr=%0d data=%h",
                     o.addr, o.data, e.addr, e.data);
         end
      end
      exp_q.delete();
      rd_ptr = n_obs;
      model_begin();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({s_ready, busy, start_CNN, frame_done, ifm_wr_en, err_len, ifm_wr_addr, ifm_wr_mask} !== '0
          || ifm_wr_data !== '0) begin
         n_fail++;
         $display("FAIL midframe_reset: got ready/busy=%b%b addr=%0d, expected all 0",
                  s_ready, busy, ifm_wr_addr);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      test_full_frame(0);
   endtask

   task automatic test_spurious();
      int  k, st0, fd0;
      wr_t e, o;
      st0 = n_start;
      fd0 = n_fd;
      pulse_load();
      model_begin();
      send_pixels(0, 50, -1, 0, k);
      load_start = 1'b1;
      done_CNN   = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      done_CNN   = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, s_ready} !== 2'b11 || n_fd !== fd0) begin
         n_fail++;
         $display("FAIL spurious_load: got busy/ready=%b fd=%0d, expected 11 fd=0",
                  {busy, s_ready}, n_fd - fd0);
      end
      send_pixels(50, TOTAL, -1, 0, k);
      model_end();
      repeat (4) @(negedge clk);
      n_checks++;
      if (n_obs - rd_ptr !== exp_q.size()) begin
         n_fail++;
         $display("FAIL nolast_wr_count: got %0d, expected %0d", n_obs - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < n_obs) begin
         e = exp_q.pop_front();
         o = obs_arr[rd_ptr];
         rd_ptr++;
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL nolast_wr_word: got addr=%0d mask=%h, expected addr=%0d mask=%h",
                     o.addr, o.mask, e.addr, e.mask);
         end
      end
      exp_q.delete();
      rd_ptr = n_obs;
      n_checks++;
      if (err_len !== 1'b1 || n_start - st0 !== 1) begin
         n_fail++;
         $display("FAIL nolast_err: got err=%b starts=%0d, expected err=1 starts=1",
                  err_len, n_start - st0);
      end
      @(negedge clk) load_start = 1'b1;
      @(negedge clk) load_start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || s_ready !== 1'b0 || n_start - st0 !== 1 || err_len !== 1'b1) begin
         n_fail++;
         $display("FAIL spurious_run: got busy=%b ready=%b starts=%0d err=%b, expected 1 0 1 1",
                  busy, s_ready, n_start - st0, err_len);
      end
      fire_done(5);
      n_checks++;
      if (n_fd - fd0 !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_done: got %0d pulses busy=%b, expected 1 busy=0", n_fd - fd0, busy);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      done_CNN   = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_full_frame(0);
      test_full_frame(30);
      test_short_frame();
      test_reset_midframe();
      test_spurious();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
